// File: rtl/command_exec.sv
`default_nettype none
// ============================================================================
//  Module   : command_exec
//  Purpose  : Decodes validated commands from the UART command framer,
//             executes register writes/reads, version and statistics
//             queries, and issues exactly one reply per executed command
//             through the framer's transmit handshake. Owns the board's
//             control register bank.
//  Ports    : clk, rst (async, active-high)
//             command_rx_ready/command_rx/data_field_rx  - receive side
//             command_tx_ready/command_tx/data_field_tx  - reply request
//             command_tx_status/command_tx_over          - framer tx status
//             version           - firmware version word
//             ctrl_regs         - flat register bank, reg n at [n*32+:32]
//             reg_wr_pulse      - one-cycle strobe per register written
//             tx_timeout_err    - sticky reply timeout flag
//  Options  : CMD_TX_TIMEOUT_EN - abandon a reply after TX_TIMEOUT cycles
//  Revision : 1.0 - initial release
// ============================================================================
module command_exec #(
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] TX_TIMEOUT = 32'd200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     command_rx_ready,
  input  logic [7:0]               command_rx,
  input  logic [31:0]              data_field_rx,
  output logic                     command_tx_ready,
  output logic [7:0]               command_tx,
  output logic [31:0]              data_field_tx,
  input  logic                     command_tx_status,
  input  logic                     command_tx_over,
  input  logic [31:0]              version,
  output logic [NUM_REGS*32-1:0]   ctrl_regs,
  output logic [NUM_REGS-1:0]      reg_wr_pulse,
  output logic                     tx_timeout_err
);

  localparam logic [4:0] C_NUM_REGS = 5'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EXEC      = 2'd1,
    S_REQ       = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cap_op_q;
  logic [31:0]   cap_data_q;
  logic          hold_valid_q;
  logic [7:0]    hold_op_q;
  logic [31:0]   hold_data_q;
  logic [15:0]   rx_cnt_q;
  logic [15:0]   drop_cnt_q;
  logic [7:0]    tx_op_q;
  logic [31:0]   tx_data_q;
  logic [31:0]   regs_q [NUM_REGS];

  logic          timeout_w;
  logic [3:0]    idx_w;
  logic          idx_ok_w;
  logic          wr_hit_w;
  logic          rd_hit_w;
  logic [31:0]   rd_data_w;
  logic [7:0]    reply_op_w;
  logic [31:0]   reply_data_w;
  logic [NUM_REGS-1:0] wr_pulse_w;

  // --------------------------------------------------------------------------
  // Opcode decode of the captured command
  // --------------------------------------------------------------------------
  assign idx_w    = cap_op_q[3:0];
  assign idx_ok_w = ({1'b0, idx_w} < C_NUM_REGS);
  assign wr_hit_w = (cap_op_q[7:4] == 4'h1) && idx_ok_w;
  assign rd_hit_w = (cap_op_q[7:4] == 4'h2) && idx_ok_w;

  always_comb begin
    rd_data_w = 32'h0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (idx_w == 4'(n)) rd_data_w = regs_q[n];
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_REGS; n++) begin
      wr_pulse_w[n] = (state_q == S_EXEC) && wr_hit_w && (idx_w == 4'(n));
    end
  end

  always_comb begin
    reply_op_w   = 8'hEE;
    reply_data_w = {24'h0, cap_op_q};
    if (cap_op_q == 8'h01) begin
      reply_op_w   = 8'h81;
      reply_data_w = version;
    end else if (cap_op_q == 8'h02) begin
      reply_op_w   = 8'h82;
      reply_data_w = {rx_cnt_q, drop_cnt_q};
    end else if (wr_hit_w) begin
      reply_op_w   = {4'h9, idx_w};
      reply_data_w = cap_data_q;
    end else if (rd_hit_w) begin
      reply_op_w   = {4'hA, idx_w};
      reply_data_w = rd_data_w;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (hold_valid_q || command_rx_ready) state_d = S_EXEC;
      S_EXEC:      state_d = S_REQ;
      // A completion seen while still requesting means the status pulse was
      // missed; the reply is done regardless.
      S_REQ: begin
        if (timeout_w || command_tx_over) state_d = S_IDLE;
        else if (command_tx_status)       state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (timeout_w || command_tx_over) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: input buffering, counters, reply latch, register bank
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_op_q     <= 8'h0;
      cap_data_q   <= 32'h0;
      hold_valid_q <= 1'b0;
      hold_op_q    <= 8'h0;
      hold_data_q  <= 32'h0;
      rx_cnt_q     <= 16'h0;
      drop_cnt_q   <= 16'h0;
      tx_op_q      <= 8'h0;
      tx_data_q    <= 32'h0;
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= 32'h0;
    end else begin
      if (state_q == S_IDLE && hold_valid_q) begin
        cap_op_q     <= hold_op_q;
        cap_data_q   <= hold_data_q;
        hold_valid_q <= 1'b0;
      end
      if (command_rx_ready) begin
        if (rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
        if (state_q == S_IDLE && !hold_valid_q) begin
          cap_op_q   <= command_rx;
          cap_data_q <= data_field_rx;
        end else if (state_q == S_IDLE || !hold_valid_q) begin
          // In IDLE with a full buffer the buffer drains this cycle, so the
          // new command can take its place.
          hold_op_q    <= command_rx;
          hold_data_q  <= data_field_rx;
          hold_valid_q <= 1'b1;
        end else if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end
      if (state_q == S_EXEC) begin
        tx_op_q   <= reply_op_w;
        tx_data_q <= reply_data_w;
      end
      for (int n = 0; n < NUM_REGS; n++) begin
        if (wr_pulse_w[n]) regs_q[n] <= cap_data_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional reply timeout
  // --------------------------------------------------------------------------
`ifdef CMD_TX_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        to_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= 32'h0;
      to_err_q <= 1'b0;
    end else begin
      if (state_q == S_EXEC)
        to_cnt_q <= 32'h0;
      else if (state_q == S_REQ || state_q == S_WAIT_DONE)
        to_cnt_q <= to_cnt_q + 32'd1;
      if (timeout_w) to_err_q <= 1'b1;
    end
  end

  // Counter is 0 in the first REQ cycle, so the last allowed cycle holds
  // TX_TIMEOUT-1.
  assign timeout_w      = (state_q == S_REQ || state_q == S_WAIT_DONE) &&
                          (to_cnt_q == TX_TIMEOUT - 32'd1);
  assign tx_timeout_err = to_err_q;
`else
  assign timeout_w      = 1'b0;
  assign tx_timeout_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign command_tx_ready = (state_q == S_REQ);
  assign command_tx       = tx_op_q;
  assign data_field_tx    = tx_data_q;
  assign reg_wr_pulse     = wr_pulse_w;

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
      assign ctrl_regs[g*32 +: 32] = regs_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_command_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_command_exec
//  Purpose  : Self-checking bench for command_exec. Expected replies are
//             queued when a command is driven and compared when the DUT
//             raises its reply request.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_command_exec;

  localparam int          NUM_REGS = 8;
  localparam logic [31:0] VER      = 32'h20160403;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   command_rx_ready = 1'b0;
  logic [7:0]             command_rx = 8'h0;
  logic [31:0]            data_field_rx = 32'h0;
  logic                   command_tx_ready;
  logic [7:0]             command_tx;
  logic [31:0]            data_field_tx;
  logic                   command_tx_status = 1'b0;
  logic                   command_tx_over = 1'b0;
  logic [31:0]            version = VER;
  logic [NUM_REGS*32-1:0] ctrl_regs;
  logic [NUM_REGS-1:0]    reg_wr_pulse;
  logic                   tx_timeout_err;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q [$];

  command_exec #(.NUM_REGS(NUM_REGS), .TX_TIMEOUT(32'd100)) dut (
    .clk               (clk),
    .rst               (rst),
    .command_rx_ready  (command_rx_ready),
    .command_rx        (command_rx),
    .data_field_rx     (data_field_rx),
    .command_tx_ready  (command_tx_ready),
    .command_tx        (command_tx),
    .data_field_tx     (data_field_tx),
    .command_tx_status (command_tx_status),
    .command_tx_over   (command_tx_over),
    .version           (version),
    .ctrl_regs         (ctrl_regs),
    .reg_wr_pulse      (reg_wr_pulse),
    .tx_timeout_err    (tx_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    command_rx_ready = 1'b0;
    command_tx_status = 1'b0;
    command_tx_over = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // One-cycle receive pulse; returns 1 time unit after the sampling edge,
  // i.e. in the cycle the DUT is executing (when it was idle).
  task automatic send_cmd(input logic [7:0] op, input logic [31:0] data);
    @(posedge clk); #1;
    command_rx_ready = 1'b1;
    command_rx = op;
    data_field_rx = data;
    @(posedge clk); #1;
    command_rx_ready = 1'b0;
  endtask

  // Waits for the reply request, compares it against the scoreboard head,
  // then plays the framer: status, release check, completion pulse.
  task automatic serve_reply(input int stall);
    logic [39:0] exp;
    int t;
    t = 0;
    while (command_tx_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (command_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reply_wait: command_tx_ready=%b required 1", command_tx_ready);
      return;
    end
    repeat (stall) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL reply_unexpected: got %h/%h, no reply expected", command_tx, data_field_tx);
    end else begin
      exp = exp_q.pop_front();
      if ({command_tx, data_field_tx} !== exp) begin
        errors++;
        $display("FAIL reply_value: got op %h data %h required op %h data %h",
                 command_tx, data_field_tx, exp[39:32], exp[31:0]);
      end
    end
    command_tx_status = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (command_tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reply_release: command_tx_ready=%b required 0", command_tx_ready);
    end
    repeat (2) @(posedge clk);
    #1 command_tx_over = 1'b1;
    @(posedge clk); #1;
    command_tx_over = 1'b0;
    command_tx_status = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({command_tx_ready, command_tx, data_field_tx, reg_wr_pulse, tx_timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b op=%h data=%h pulse=%h err=%b required all 0",
               command_tx_ready, command_tx, data_field_tx, reg_wr_pulse, tx_timeout_err);
    end
    checks++;
    if (ctrl_regs !== '0) begin
      errors++;
      $display("FAIL reset_regs: ctrl_regs=%h required 0", ctrl_regs);
    end
    do_reset();
  endtask

  task automatic test_version();
    exp_q.push_back({8'h81, VER});
    send_cmd(8'h01, 32'h0);
    checks++;
    if (command_tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: command_tx_ready=%b required 0", command_tx_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (command_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_n2: command_tx_ready=%b required 1", command_tx_ready);
    end
    serve_reply(3);
    exp_q.push_back({8'h81, VER});
    send_cmd(8'h01, 32'hFFFF_FFFF);
    serve_reply(0);
  endtask

  task automatic test_write_read();
    exp_q.push_back({8'h93, 32'hDEADBEEF});
    send_cmd(8'h13, 32'hDEADBEEF);
    checks++;
    if (reg_wr_pulse !== 8'h08) begin
      errors++;
      $display("FAIL wr_pulse: reg_wr_pulse=%h required 08", reg_wr_pulse);
    end
    @(posedge clk); #1;
    checks++;
    if (reg_wr_pulse !== 8'h00) begin
      errors++;
      $display("FAIL wr_pulse_len: reg_wr_pulse=%h required 00", reg_wr_pulse);
    end
    checks++;
    if (ctrl_regs !== {128'h0, 32'hDEADBEEF, 96'h0}) begin
      errors++;
      $display("FAIL wr_reg3: ctrl_regs=%h required DEADBEEF in reg 3 only", ctrl_regs);
    end
    serve_reply(0);
    exp_q.push_back({8'hA3, 32'hDEADBEEF});
    send_cmd(8'h23, 32'h0);
    serve_reply(1);
    exp_q.push_back({8'hA0, 32'h0});
    send_cmd(8'h20, 32'h1234);
    serve_reply(0);
  endtask

  task automatic test_illegal();
    logic [7:0] ops [3];
    ops = '{8'h18, 8'h55, 8'h28};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'hEE, 24'h0, ops[i]});
      send_cmd(ops[i], 32'hCAFE_0000 + 32'(i));
      checks++;
      if (reg_wr_pulse !== 8'h00) begin
        errors++;
        $display("FAIL illegal_pulse: op %h reg_wr_pulse=%h required 00", ops[i], reg_wr_pulse);
      end
      serve_reply(0);
    end
    checks++;
    if (ctrl_regs !== {128'h0, 32'hDEADBEEF, 96'h0}) begin
      errors++;
      $display("FAIL illegal_regs: ctrl_regs=%h required unchanged", ctrl_regs);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back({8'h81, VER});
    send_cmd(8'h01, 32'h0);
    @(posedge clk); #1;
    exp_q.push_back({8'h94, 32'h12345678});
    send_cmd(8'h14, 32'h12345678);   // buffered
    send_cmd(8'h21, 32'h0);          // dropped
    serve_reply(2);
    serve_reply(0);
    checks++;
    if (ctrl_regs[159:128] !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_reg4: reg4=%h required 12345678", ctrl_regs[159:128]);
    end
    exp_q.push_back({8'h82, 16'h0004, 16'h0001});
    send_cmd(8'h02, 32'h0);
    serve_reply(0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending: %0d replies outstanding required 0", exp_q.size());
    end
  endtask

`ifdef CMD_TX_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    send_cmd(8'h01, 32'h0);
    @(posedge clk); #1;
    n = 0;
    while (command_tx_ready === 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL timeout_len: ready high %0d cycles required 100", n);
    end
    checks++;
    if (tx_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err: tx_timeout_err=%b required 1", tx_timeout_err);
    end
    exp_q.push_back({8'h81, VER});
    send_cmd(8'h01, 32'h0);
    serve_reply(0);
  endtask
`endif

  task automatic test_async_reset();
    int t;
    exp_q.push_back({8'h91, 32'h5});
    send_cmd(8'h11, 32'h5);
    t = 0;
    while (command_tx_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    command_tx_status = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (command_tx !== 8'h91 || command_tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_hold: op=%h ready=%b required 91/0", command_tx, command_tx_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({command_tx_ready, command_tx, data_field_tx, reg_wr_pulse, tx_timeout_err} !== '0 ||
        ctrl_regs !== '0) begin
      errors++;
      $display("FAIL async_reset: op=%h data=%h regs=%h required all 0",
               command_tx, data_field_tx, ctrl_regs);
    end
    command_tx_status = 1'b0;
    do_reset();
    exp_q.push_back({8'h82, 16'h0001, 16'h0000});
    send_cmd(8'h02, 32'h0);
    serve_reply(0);
  endtask

  initial begin
    test_reset();
    test_version();
    test_write_read();
    test_illegal();
    test_back_to_back();
`ifdef CMD_TX_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
